// File: rtl/cache_ctrl_dm.sv
// cache_ctrl_dm: direct-mapped write-back cache controller, one word per line.
// Serves flush/read/write (optionally one-level indirect) over req/done.
// Ports: clk, clr (async active-low reset), req/cmd/ind/addr/wdata in,
//   rdata/done/busy out; mem_req/mem_we/mem_addr/mem_wdata to RAM,
//   mem_rdata/mem_ack from RAM; hit_cnt/miss_cnt lookup statistics.
// Define CACHE_STATS_EN to build the saturating hit/miss counters;
//   otherwise hit_cnt and miss_cnt are tied to zero.
module cache_ctrl_dm #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int IDX_W  = 2,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              req,
   input  logic [1:0]        cmd,
   input  logic              ind,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              done,
   output logic              busy,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [CNT_W-1:0]  miss_cnt
);

   localparam int TAG_W = ADDR_W - IDX_W;
   localparam int LINES = 1 << IDX_W;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(LINES - 1);

   typedef enum logic [2:0] {
      IDLE, LOOKUP, WBACK, FETCH, ACCESS, INDIR, FLUSH, DONE
   } state_t;

   state_t            state;
   logic [1:0]        cmd_l;
   logic              ind_l;
   logic [ADDR_W-1:0] addr_l;
   logic [DATA_W-1:0] wdata_l;
   logic [IDX_W-1:0]  fidx;
   logic [LINES-1:0]  vld;
   logic [LINES-1:0]  dty;
   logic [TAG_W-1:0]  tags  [LINES];
   logic [DATA_W-1:0] lines [LINES];

   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tg;
   logic              hit;
   logic              rd_op;
   logic              vdirty;

   assign idx    = addr_l[IDX_W-1:0];
   assign tg     = addr_l[ADDR_W-1:IDX_W];
   assign hit    = vld[idx] && (tags[idx] == tg);
   assign vdirty = vld[idx] && dty[idx];
   // the pointer-fetch pass of an indirect access is always a read
   assign rd_op  = (cmd_l == 2'b10) || ind_l;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state     <= IDLE;
         cmd_l     <= '0;
         ind_l     <= 1'b0;
         addr_l    <= '0;
         wdata_l   <= '0;
         fidx      <= '0;
         vld       <= '0;
         dty       <= '0;
         rdata     <= '0;
         done      <= 1'b0;
         busy      <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         for (int i = 0; i < LINES; i++) begin
            tags[i]  <= '0;
            lines[i] <= '0;
         end
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (req) begin
                  cmd_l   <= cmd;
                  ind_l   <= ind & cmd[1];
                  addr_l  <= addr;
                  wdata_l <= wdata;
                  busy    <= 1'b1;
                  fidx    <= '0;
                  unique case (1'b1)
                     (cmd == 2'b00): state <= FLUSH;
                     cmd[1]:         state <= LOOKUP;
                     default: begin
                        state <= DONE;
                        done  <= 1'b1;
                     end
                  endcase
               end
            end
            LOOKUP: begin
               if (hit)         state <= ACCESS;
               else if (vdirty) state <= WBACK;
               else if (rd_op)  state <= FETCH;
               else             state <= ACCESS;
            end
            WBACK: begin
               // first cycle issues, then hold until ack
               if (!mem_req) begin
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_addr  <= {tags[idx], idx};
                  mem_wdata <= lines[idx];
               end else if (mem_ack) begin
                  mem_req  <= 1'b0;
                  mem_we   <= 1'b0;
                  dty[idx] <= 1'b0;
                  state    <= rd_op ? FETCH : ACCESS;
               end
            end
            FETCH: begin
               if (!mem_req) begin
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= addr_l;
               end else if (mem_ack) begin
                  mem_req    <= 1'b0;
                  lines[idx] <= mem_rdata;
                  tags[idx]  <= tg;
                  vld[idx]   <= 1'b1;
                  dty[idx]   <= 1'b0;
                  state      <= ACCESS;
               end
            end
            ACCESS: begin
               if (rd_op) begin
                  rdata <= lines[idx];
               end else begin
                  lines[idx] <= wdata_l;
                  tags[idx]  <= tg;
                  vld[idx]   <= 1'b1;
                  dty[idx]   <= 1'b1;
               end
               if (ind_l) begin
                  state <= INDIR;
               end else begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            INDIR: begin
               addr_l <= rdata[ADDR_W-1:0];
               ind_l  <= 1'b0;
               state  <= LOOKUP;
            end
            FLUSH: begin
               if (mem_req) begin
                  if (mem_ack) begin
                     mem_req   <= 1'b0;
                     mem_we    <= 1'b0;
                     vld[fidx] <= 1'b0;
                     dty[fidx] <= 1'b0;
                     if (fidx == LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                     end else begin
                        fidx <= fidx + IDX_W'(1);
                     end
                  end
               end else if (vld[fidx] && dty[fidx]) begin
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_addr  <= {tags[fidx], fidx};
                  mem_wdata <= lines[fidx];
               end else begin
                  vld[fidx] <= 1'b0;
                  if (fidx == LAST) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     fidx <= fidx + IDX_W'(1);
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CACHE_STATS_EN
   logic [CNT_W-1:0] hit_q;
   logic [CNT_W-1:0] miss_q;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         hit_q  <= '0;
         miss_q <= '0;
      end else if (state == LOOKUP) begin
         if (hit) begin
            if (hit_q != '1) hit_q <= hit_q + CNT_W'(1);
         end else begin
            if (miss_q != '1) miss_q <= miss_q + CNT_W'(1);
         end
      end
   end

   assign hit_cnt  = hit_q;
   assign miss_cnt = miss_q;
`else
   assign hit_cnt  = '0;
   assign miss_cnt = '0;
`endif

endmodule

// File: doc/cache_ctrl_dm.md
# cache_ctrl_dm

Parametrised direct-mapped write-back cache controller with an internal tag/valid/dirty/data store, sitting between the processor datapath and main RAM. It serves read, write and flush commands over a req/done handshake, fetches on read miss and writes back dirty victims. It also supports single-level indirect access, in which the word read at the request address becomes the address actually operated on.

## Interface
Parameters:
- ADDR_W, 8, address width; index = addr[IDX_W-1:0], tag = addr[ADDR_W-1:IDX_W]
- DATA_W, 8, word width; one word per line; must be ≥ ADDR_W
- IDX_W, 2, index width; LINES = 2^IDX_W
- CNT_W, 16, statistics counter width (used only with CACHE_STATS_EN)

Ports:
- clk  in  1  single clock, rising edge
- clr  in  1  asynchronous active-low reset
- req  in  1  command request, sampled only in IDLE
- cmd  in  2  00 flush, 10 read, 11 write; 01 is accepted as a no-op that completes with done
- ind  in  1  indirect access for read/write; ignored for flush
- addr  in  ADDR_W  request address
- wdata  in  DATA_W  write data
- rdata  out  DATA_W  read result, valid while done=1, held until next done
- done  out  1  one-cycle completion pulse
- busy  out  1  high from acceptance until the done cycle, inclusive
- mem_req  out  1  RAM request
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid with mem_ack
- mem_ack  in  1  RAM completion
- hit_cnt  out  CNT_W  lookup hits
- miss_cnt  out  CNT_W  lookup misses

## Operation
- States: IDLE, LOOKUP, WBACK, FETCH, ACCESS, INDIR, FLUSH, DONE.
- IDLE: when req=1, latch cmd/ind/addr/wdata and set busy. Flush goes to FLUSH; read/write go to LOOKUP; no-op goes to DONE.
- LOOKUP: hit = valid & tag match.
  - Read hit goes to ACCESS. Read miss goes to WBACK if the victim is valid and dirty, else to FETCH.
  - Write hit, or write miss with a clean or invalid victim, goes to ACCESS. Write miss with a dirty victim goes to WBACK.
  - During the first indirect pass the operation is treated as a read regardless of cmd.
- WBACK: write the victim to RAM at {victim_tag, index}. On mem_ack, go to FETCH for a read, else to ACCESS.
- FETCH: read RAM at the current address. On mem_ack, fill the line: valid=1, dirty=0, new tag.
- ACCESS:
  - Read: capture the line data.
  - Write: store wdata, set valid=1 and dirty=1, set tag.
  - If ind is latched, go to INDIR; otherwise go to DONE.
- INDIR: addr ← captured data[ADDR_W-1:0], clear the latched ind, go to LOOKUP. Exactly one level of indirection.
- FLUSH: walk index 0..LINES-1 in ascending order. Each valid dirty line is written back. Every line is then invalidated. After the last index, go to DONE.
- DONE: pulse done for one cycle, clear busy, return to IDLE.
- Writes leave rdata unchanged; indirect writes update rdata with the pointer word.
- RAM handshake:
  - mem_req and mem_addr/mem_we/mem_wdata are held stable until mem_ack is sampled high.
  - mem_req drops on the following cycle.
  - Any number of wait states is allowed.
  - mem_ack while mem_req=0 is ignored.

## Timing
- Reset (clr=0, asynchronous):
  - State returns to IDLE.
  - All valid and dirty bits are cleared; dirty data is discarded.
  - busy=0, done=0, rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, counters=0.
  - Takes effect immediately, including mid-transaction.
- Hit latency: req is sampled at edge E0; LOOKUP runs after E0, ACCESS after E1, and done is high in the cycle after E2.
- Each RAM transaction adds 1 issue cycle plus the wait states until mem_ack.
- req while busy=1 is ignored and not queued. req held high in the done cycle is ignored; it is sampled again in IDLE.
- Flush takes LINES cycles plus the RAM transactions, plus the DONE cycle.

## Configuration
- CACHE_STATS_EN defined:
  - Each LOOKUP increments hit_cnt or miss_cnt; both indirect passes count.
  - Counters saturate at all-ones.
  - Counters are reset only by clr; flush does not clear them.
- CACHE_STATS_EN undefined: hit_cnt and miss_cnt are tied to 0 and no counter logic is synthesised.

## Test plan
- **Read miss then hit:** reset, RAM[0x05]=0x3C, read 0x05 → one mem read at 0x05, rdata=0x3C, miss_cnt=1. Read 0x05 again → no mem_req, done 2 cycles after acceptance, hit_cnt=1.
- **Dirty eviction:** write 0x05←0xA1 (hit, no RAM traffic), then read 0x09 with RAM[0x09]=0x44 → mem write 0x05/0xA1 first, then mem read 0x09, rdata=0x44.
- **Indirect read:** RAM[0x02]=0x11, RAM[0x11]=0x7E, read ind=1 at 0x02 → mem reads 0x02 then 0x11, rdata=0x7E, miss_cnt +2.
- **Indirect write:** with the line at 0x02 holding 0x11, write ind=1 addr 0x02 wdata 0x99 → line 0x11 holds 0x99 (dirty), line 0x02 unchanged, rdata=0x11.
- **Flush:** lines 0 and 3 dirty, line 1 clean → exactly two mem writes (index 0, then index 3), then done; re-reads of all three addresses miss.
- **Reset and busy behaviour:** assert clr while mem_req=1 awaiting ack → mem_req, busy and done read 0 immediately; after release, a read of the same address misses. A req pulsed while busy=1 produces no extra done.
